branch_resolve_bht: RTL and testbench
=====================================

# branch_resolve_bht

Parametrised successor to the pipeline's branch compare logic. The block resolves MIPS conditional branches (BLTZ/BLTZAL, BGEZ/BGEZAL, BEQ, BNE, BLEZ, BGTZ) and jumps with a registered outcome. It also keeps a table of 2-bit saturating counters that gives fetch a taken/not-taken prediction. It sits between ID (operands, instruction, fetch-time prediction) and the PC-select/flush logic, and adds branch and mispredict statistics counters.

## Interface
- WIDTH, 32, operand width; sign bit is WIDTH-1
- BHT_DEPTH, 64, number of prediction counters; power of 2, minimum 2
- IDX_LSB, 2, lowest PC bit used for the table index; index width IW = log2(BHT_DEPTH)
- STAT_W, 16, width of the statistics counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  32  fetch PC used for the lookup
- if_pred_taken  out  1  combinational: bit 1 of counter[if_pc[IDX_LSB +: IW]]
- id_valid  in  1  ID holds a valid instruction this cycle
- id_pc  in  32  PC of the ID instruction
- id_instr  in  32  ID instruction word
- id_jump  in  1  ID instruction is an unconditional jump
- id_pred_taken  in  1  prediction fetch used for this instruction
- op_a, op_b  in  WIDTH  forwarded operands
- stat_clr  in  1  synchronous clear of the statistics counters
- res_valid  out  1  registered; a resolved branch or jump is present
- res_taken  out  1  registered resolved direction
- res_mispredict  out  1  registered; res_taken != id_pred_taken
- res_pc  out  32  registered id_pc of the resolved instruction
- stat_branches  out  STAT_W  count of resolved conditional branches
- stat_mispredicts  out  STAT_W  count of mispredicted branches and jumps

## Operation
- Decode on id_instr[31:26]:
  - 000001 with rt (id_instr[20:16]) = 00000 or 10000 → taken when op_a[WIDTH-1] is 1.
  - 000001 with rt = 00001 or 10001 → taken when op_a[WIDTH-1] is 0.
  - 000001 with any other rt is not a branch.
  - 000100: taken when op_a==op_b.
  - 000101: taken when op_a!=op_b.
  - 000110: taken when sign=1 or op_a==0.
  - 000111: taken when sign=0 and op_a!=0.
  - Any other opcode is not a branch.
- is_br means the decode above matched. cond is its result.
- act = id_valid & (is_br | id_jump). taken = cond | id_jump.
- At each edge:
  - res_valid ← act.
  - When act=1, res_taken ← taken and res_mispredict ← (taken != id_pred_taken).
  - When act=0, res_taken and res_mispredict are set to 0.
  - res_pc ← id_pc when act=1, otherwise it holds.
- Table update when id_valid & is_br: counter at id_pc[IDX_LSB +: IW] increments on cond=1 (saturates at 3) and decrements on cond=0 (saturates at 0).
- Jumps never update the table.
- stat_branches increments on id_valid & is_br.
- stat_mispredicts increments on act & mispredict.
- Both statistics counters saturate at all-ones and do not wrap.
- stat_clr has priority over the increments: both counters are set to 0 that cycle.
- Encoding 10 or 11 predicts taken. Counter reset value is 01 (weakly not-taken).

## Timing
- Resolve latency: 1 cycle from the id_valid edge to res_*.
- Prediction lookup: 0 cycles, combinational from if_pc and the current table.
- Update and lookup of the same index in one cycle: if_pred_taken shows the pre-update value. The new value is visible the next cycle.
- Back-to-back branches to the same index: the updates accumulate each cycle with no lost update.
- Reset (asynchronous, any time, including mid-resolve):
  - All counters return to 01.
  - res_valid, res_taken, res_mispredict and res_pc go to 0.
  - Statistics counters go to 0.
  - No pending update survives reset.
- After rst_n rises, the first edge with id_valid=1 behaves normally.
- id_valid=0 means no state changes except stat_clr.
- Operands are sampled only on the edge; no internal storage of operands.

## Test plan
- Reset, then if_pc=0x100 → if_pred_taken=0. All res_* and statistics outputs read 0.
- BEQ (opcode 000100) at id_pc=0x40:
  - op_a=op_b=5 with id_pred_taken=0 → next cycle res_valid=1, res_taken=1, res_mispredict=1, res_pc=0x40, stat_branches=1, stat_mispredicts=1.
  - Then if_pc=0x40 → if_pred_taken=1 (counter 10).
- Saturation: BGTZ at id_pc=0x80 with op_a=1, repeated 3 times → counter reaches 3. Then one not-taken (op_a=0) → counter 2, still predicts taken.
- Sign decode:
  - WIDTH=16, BLTZ (opcode 000001, rt=00000), op_a=0x8000 → taken.
  - BGEZAL (rt=10001), op_a=0x7FFF → taken.
  - rt=00011 → res_valid=0 and no counter change.
- Jump with id_jump=1, id_pred_taken=0:
  - res_taken=1, res_mispredict=1, stat_mispredicts increments, stat_branches unchanged, table unchanged.
  - Same-index lookup during a BNE update returns the old value.
- Counters:
  - STAT_W=4, 20 mispredicts → stat_mispredicts=15.
  - stat_clr asserted together with a branch → both counters 0.
  - rst_n pulsed low mid-sequence → all state returns to the reset values asynchronously.

Source files
------------

// File: rtl/branch_resolve_bht_if.sv
// ID-side branch bus: fetch lookup, ID operands/instruction, registered resolution and statistics.
interface branch_resolve_bht_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAT_W = 16
);
  logic [31:0]       if_pc;
  logic              if_pred_taken;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_instr;
  logic              id_jump;
  logic              id_pred_taken;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              stat_clr;
  logic              res_valid;
  logic              res_taken;
  logic              res_mispredict;
  logic [31:0]       res_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output if_pc, id_valid, id_pc, id_instr, id_jump, id_pred_taken, op_a, op_b, stat_clr,
    input  if_pred_taken, res_valid, res_taken, res_mispredict, res_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, id_valid, id_pc, id_instr, id_jump, id_pred_taken, op_a, op_b, stat_clr,
    output if_pred_taken, res_valid, res_taken, res_mispredict, res_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// MIPS conditional branch/jump resolver with a 2-bit saturating-counter prediction table
// and saturating branch/mispredict statistics.
module branch_resolve_bht #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned IDX_LSB   = 2,
  parameter int unsigned STAT_W    = 16
) (
  input logic                clk,
  input logic                rst_n,
  branch_resolve_bht_if.slave bus
);
  localparam int unsigned IW = $clog2(BHT_DEPTH);

  logic [1:0]        bht_q [BHT_DEPTH];
  logic              res_valid_q, res_taken_q, res_mispredict_q;
  logic [31:0]       res_pc_q;
  logic [STAT_W-1:0] br_cnt_q, mp_cnt_q;

  logic [5:0]    opcode;
  logic [4:0]    rt;
  logic          sign, zero, eq;
  logic          is_br, cond, act, taken, mispredict;
  logic [IW-1:0] upd_idx;
  logic          unused_bits;

  assign opcode  = bus.id_instr[31:26];
  assign rt      = bus.id_instr[20:16];
  assign sign    = bus.op_a[WIDTH-1];
  assign zero    = (bus.op_a == '0);
  assign eq      = (bus.op_a == bus.op_b);
  assign upd_idx = bus.id_pc[IDX_LSB +: IW];
  // Only a slice of each PC and instruction word is decoded.
  assign unused_bits = ^{bus.id_instr, bus.if_pc, bus.id_pc};

  always_comb begin
    is_br = 1'b0;
    cond  = 1'b0;
    unique case (opcode)
      6'b000001: begin
        unique case (rt)
          5'b00000, 5'b10000: begin is_br = 1'b1; cond = sign;  end
          5'b00001, 5'b10001: begin is_br = 1'b1; cond = !sign; end
          default: ;
        endcase
      end
      6'b000100: begin is_br = 1'b1; cond = eq;               end
      6'b000101: begin is_br = 1'b1; cond = !eq;              end
      6'b000110: begin is_br = 1'b1; cond = sign || zero;     end
      6'b000111: begin is_br = 1'b1; cond = !sign && !zero;   end
      default: ;
    endcase
  end

  assign act        = bus.id_valid && (is_br || bus.id_jump);
  assign taken      = cond || bus.id_jump;
  assign mispredict = taken != bus.id_pred_taken;

  // Lookup reads the table state before this edge's update.
  assign bus.if_pred_taken = bht_q[bus.if_pc[IDX_LSB +: IW]][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (bus.id_valid && is_br) begin
      if (cond && bht_q[upd_idx] != 2'b11)
        bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      else if (!cond && bht_q[upd_idx] != 2'b00)
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_pc_q         <= '0;
    end else begin
      res_valid_q      <= act;
      res_taken_q      <= act && taken;
      res_mispredict_q <= act && mispredict;
      if (act) res_pc_q <= bus.id_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (bus.stat_clr) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (bus.id_valid && is_br && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
      if (act && mispredict && mp_cnt_q != '1)     mp_cnt_q <= mp_cnt_q + 1'b1;
    end
  end

  assign bus.res_valid        = res_valid_q;
  assign bus.res_taken        = res_taken_q;
  assign bus.res_mispredict   = res_mispredict_q;
  assign bus.res_pc           = res_pc_q;
  assign bus.stat_branches    = br_cnt_q;
  assign bus.stat_mispredicts = mp_cnt_q;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed and randomized checks of branch_resolve_bht against a behavioural model.
module tb_branch_resolve_bht;
  localparam int W  = 16;
  localparam int SW = 4;
  localparam int D  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_bht_if #(.WIDTH(W), .STAT_W(SW)) bus ();

  branch_resolve_bht #(.WIDTH(W), .BHT_DEPTH(D), .IDX_LSB(2), .STAT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int ctr [D];
  int m_br, m_mp;
  bit m_valid, m_taken, m_mp_bit;
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rt);
    logic [31:0] w;
    w = '0;
    w[31:26] = 6'(op);
    w[20:16] = 5'(rt);
    return w;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % D);
  endfunction

  // Reference semantics of the branch opcodes using signed arithmetic.
  task automatic ref_decode(input logic [31:0] ins, input logic [W-1:0] a, input logic [W-1:0] b,
                            output bit br, output bit cd);
    int sa;
    sa = int'($signed(a));
    br = 1'b1;
    cd = 1'b0;
    case (int'(ins[31:26]))
      1: begin
        if (ins[20:16] == 0 || ins[20:16] == 16)      cd = (sa < 0);
        else if (ins[20:16] == 1 || ins[20:16] == 17) cd = (sa >= 0);
        else br = 1'b0;
      end
      4: cd = (a == b);
      5: cd = (a != b);
      6: cd = (sa <= 0);
      7: cd = (sa > 0);
      default: br = 1'b0;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) ctr[i] = 1;
    m_br = 0; m_mp = 0;
    m_valid = 0; m_taken = 0; m_mp_bit = 0; m_pc = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(bus.res_valid), 32'(m_valid));
    chk({tag, ".taken"}, 32'(bus.res_taken), 32'(m_taken));
    chk({tag, ".misp"},  32'(bus.res_mispredict), 32'(m_mp_bit));
    chk({tag, ".pc"},    bus.res_pc, m_pc);
    chk({tag, ".sbr"},   32'(bus.stat_branches), 32'(m_br));
    chk({tag, ".smp"},   32'(bus.stat_mispredicts), 32'(m_mp));
  endtask

  task automatic step(input string tag, input bit v, input logic [31:0] pc, input logic [31:0] ins,
                      input bit jmp, input bit pred, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit clr, input logic [31:0] ifpc);
    bit br, cd, act, tk, mp;
    bus.id_valid = v; bus.id_pc = pc; bus.id_instr = ins; bus.id_jump = jmp;
    bus.id_pred_taken = pred; bus.op_a = a; bus.op_b = b; bus.stat_clr = clr; bus.if_pc = ifpc;
    #1;
    chk({tag, ".pred"}, 32'(bus.if_pred_taken), 32'(ctr[idx_of(ifpc)] >= 2));
    @(posedge clk);
    ref_decode(ins, a, b, br, cd);
    act = v && (br || jmp);
    tk  = cd || jmp;
    mp  = tk != pred;
    m_valid = act; m_taken = act && tk; m_mp_bit = act && mp;
    if (act) m_pc = pc;
    if (v && br) ctr[idx_of(pc)] = cd ? ((ctr[idx_of(pc)] < 3) ? ctr[idx_of(pc)] + 1 : 3)
                                      : ((ctr[idx_of(pc)] > 0) ? ctr[idx_of(pc)] - 1 : 0);
    if (clr) begin
      m_br = 0; m_mp = 0;
    end else begin
      if (v && br && m_br < 15) m_br++;
      if (act && mp && m_mp < 15) m_mp++;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic [31:0] ifpc);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, ifpc);
  endtask

  logic [W-1:0] pool [6];

  initial begin
    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h7FFF;
    pool[3] = 16'h8000; pool[4] = 16'hFFFF; pool[5] = 16'h0005;
    model_reset();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_instr = 0; bus.id_jump = 0;
    bus.id_pred_taken = 0; bus.op_a = 0; bus.op_b = 0; bus.stat_clr = 0; bus.if_pc = 32'h100;
    #12;
    chk("reset.pred", 32'(bus.if_pred_taken), 32'd0);
    check_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    step("beq", 1, 32'h40, mk(4, 0), 0, 0, 5, 5, 0, 32'h100);
    chk("beq.taken_abs", 32'(bus.res_taken), 32'd1);
    chk("beq.sbr_abs", 32'(bus.stat_branches), 32'd1);
    idle("beq_look", 32'h40);
    chk("beq.pred_abs", 32'(bus.if_pred_taken), 32'd1);

    for (int i = 0; i < 3; i++) step("bgtz_t", 1, 32'h80, mk(7, 0), 0, 1, 1, 0, 0, 32'h80);
    step("bgtz_nt", 1, 32'h80, mk(7, 0), 0, 1, 0, 0, 0, 32'h80);
    idle("bgtz_look", 32'h80);
    chk("bgtz.pred_abs", 32'(bus.if_pred_taken), 32'd1);

    step("bltz", 1, 32'h10, mk(1, 0), 0, 0, 16'h8000, 0, 0, 32'h10);
    chk("bltz.taken_abs", 32'(bus.res_taken), 32'd1);
    step("bgezal", 1, 32'h14, mk(1, 17), 0, 1, 16'h7FFF, 0, 0, 32'h14);
    chk("bgezal.taken_abs", 32'(bus.res_taken), 32'd1);
    step("rt3", 1, 32'h18, mk(1, 3), 0, 0, 16'h8000, 0, 0, 32'h18);
    chk("rt3.valid_abs", 32'(bus.res_valid), 32'd0);

    step("jump", 1, 32'h20, mk(2, 0), 1, 0, 0, 0, 0, 32'h20);
    chk("jump.misp_abs", 32'(bus.res_mispredict), 32'd1);
    step("bne_same", 1, 32'h40, mk(5, 0), 0, 1, 3, 4, 0, 32'h40);

    step("clr", 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 20; i++) step("mp20", 1, 32'h30, mk(2, 0), 1, 0, 0, 0, 0, 32'h30);
    chk("mp20.sat_abs", 32'(bus.stat_mispredicts), 32'd15);
    step("clr_br", 1, 32'h44, mk(4, 0), 0, 0, 1, 1, 1, 32'h44);
    chk("clr_br.sbr_abs", 32'(bus.stat_branches), 32'd0);
    chk("clr_br.smp_abs", 32'(bus.stat_mispredicts), 32'd0);

    for (int n = 0; n < 300; n++) begin
      int ops [7] = '{1, 4, 5, 6, 7, 2, 0};
      int rts [5] = '{0, 1, 16, 17, 3};
      logic [31:0] pc;
      pc = 32'($urandom_range(0, 7)) << 2;
      step("rand", ($urandom_range(0, 4) != 0), pc,
           mk(ops[$urandom_range(0, 6)], rts[$urandom_range(0, 4)]),
           ($urandom_range(0, 5) == 0), 1'($urandom), pool[$urandom_range(0, 5)],
           pool[$urandom_range(0, 5)], ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 1) != 0) ? pc : (32'($urandom_range(0, 7)) << 2));
    end

    bus.id_valid = 1; bus.id_pc = 32'h80; bus.id_instr = mk(7, 0); bus.op_a = 1;
    bus.id_jump = 0; bus.stat_clr = 0; bus.if_pc = 32'h80;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.pred", 32'(bus.if_pred_taken), 32'd0);
    check_outputs("arst");
    @(posedge clk); #1;
    check_outputs("arst_hold");
    rst_n = 1'b1;
    step("post_rst", 1, 32'h80, mk(7, 0), 0, 0, 1, 0, 0, 32'h80);
    idle("post_look", 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
